sine_sequencer: RTL and testbench

- Control/scheduling block for the 8-iteration CORDIC sine generator.
- Drives that generator's 8-bit subsample_phase frame counter and supplies a frame-stable freq_increment.
- Applies glide (portamento) toward a target frequency and exposes a small valid/ready config port for run control.
- Captures each finished sine sample and emits it with a one-cycle valid strobe to the audio output path.

---
 rtl/sine_pkg.sv | 23 ++
 rtl/glide_step.sv | 27 ++
 rtl/sine_sequencer.sv | 137 +++++++++++++
 tb/tb_sine_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared frame-slot constants, config addresses and FSM states for the
// CORDIC sine sequencer.
package sine_pkg;

    localparam int         CORDIC_ITER = 8;
    // Frame slots: 255 load, 0..7 iterations, 8 output, 9..254 idle.
    localparam logic [7:0] PH_LOAD     = 8'd255;
    localparam logic [7:0] PH_OUT      = 8'(CORDIC_ITER);
    localparam logic [7:0] PH_IDLE     = PH_OUT + 8'd1;
    localparam logic [7:0] SAMPLE_MUTE = 8'd128;

    localparam logic [1:0] CFG_FREQ  = 2'd0;
    localparam logic [1:0] CFG_CTRL  = 2'd1;
    localparam logic [1:0] CFG_GLIDE = 2'd2;
    localparam logic [1:0] CFG_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } seq_state_t;

endpackage

// File: rtl/glide_step.sv
// One portamento step: moves cur toward target by (target-cur)>>>shift,
// with a minimum step of one so the glide always lands exactly on target.
module glide_step #(
    parameter int FREQ_W = 13
) (
    input  logic [FREQ_W-1:0] cur,
    input  logic [FREQ_W-1:0] target,
    input  logic [2:0]        shift,
    output logic [FREQ_W-1:0] next_cur
);

    localparam int DW = FREQ_W + 1;

    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] step;

    // The arithmetic shift never exceeds |diff|, so cur + step cannot overshoot or wrap.
    always_comb begin
        diff = $signed({1'b0, target}) - $signed({1'b0, cur});
        step = diff >>> shift;
        if (step == '0 && diff != '0) begin
            step = diff[DW-1] ? '1 : DW'(1);
        end
        next_cur = cur + step[FREQ_W-1:0];
    end

endmodule

// File: rtl/sine_sequencer.sv
// Frame scheduler for the CORDIC sine generator: drives the subsample phase,
// glides the frequency increment once per frame and captures finished samples.
module sine_sequencer
    import sine_pkg::*;
#(
    parameter int         ACC_BITS        = 16,
    parameter logic [2:0] GLIDE_SHIFT_RST = 3'd4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_addr,
    input  logic [15:0]         cfg_data,
    output logic [7:0]          subsample_phase,
    output logic [ACC_BITS-4:0] freq_increment,
    input  logic [7:0]          sine_in,
    output logic [7:0]          sample_out,
    output logic                sample_valid,
    output logic                running
);

    localparam int FREQ_W = ACC_BITS - 3;

    seq_state_t        state;
    seq_state_t        state_next;
    logic [7:0]        phase_next;
    logic [FREQ_W-1:0] target;
    logic [FREQ_W-1:0] glided;
    logic [2:0]        glide_shift;
    logic              run;
    logic              glide_en;
    logic              frame_slot;
    logic              accept;
    logic              unused_cfg_bits;

    // The slot-9 edge of an active frame is where frequency and sample are updated;
    // config writes are held off there so they never race the glide update.
    assign frame_slot      = (state != IDLE) && (subsample_phase == PH_IDLE);
    assign cfg_ready       = !rst && !frame_slot;
    assign accept          = cfg_valid && cfg_ready;
    assign running         = (state != IDLE);
    assign unused_cfg_bits = ^cfg_data[15:FREQ_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            subsample_phase <= PH_IDLE;
        end else begin
            state           <= state_next;
            subsample_phase <= phase_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = subsample_phase + 8'd1;
        case (state)
            IDLE: begin
                phase_next = PH_IDLE;
                if (run) begin
                    state_next = RUN;
                    phase_next = PH_LOAD;
                end
            end
            RUN: begin
                if (!run) state_next = STOPPING;
            end
            STOPPING: begin
                if (run) begin
                    state_next = RUN;
                end else if (subsample_phase == PH_IDLE) begin
                    state_next = IDLE;
                    phase_next = PH_IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = PH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target      <= '0;
            run         <= 1'b0;
            glide_en    <= 1'b0;
            glide_shift <= GLIDE_SHIFT_RST;
        end else if (accept) begin
            case (cfg_addr)
                CFG_FREQ:  target <= cfg_data[FREQ_W-1:0];
                CFG_CTRL: begin
                    glide_en <= cfg_data[1];
                    run      <= cfg_data[0];
                end
                CFG_GLIDE: glide_shift <= cfg_data[2:0];
                CFG_RSVD:  ;
                default:   ;
            endcase
        end
    end

    glide_step #(
        .FREQ_W(FREQ_W)
    ) u_glide (
        .cur     (freq_increment),
        .target  (target),
        .shift   (glide_shift),
        .next_cur(glided)
    );

    // While idle the generator is not consuming the increment, so it may track freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_increment <= '0;
        end else if (state == IDLE || subsample_phase == PH_IDLE) begin
            freq_increment <= glide_en ? glided : target;
        end
    end

    // The final sample of a stop is still strobed out; the output mutes one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out   <= SAMPLE_MUTE;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= frame_slot;
            if (frame_slot) begin
                sample_out <= sine_in;
            end else if (state == IDLE) begin
                sample_out <= SAMPLE_MUTE;
            end
        end
    end

endmodule

// File: tb/tb_sine_sequencer.sv
// Directed bench for sine_sequencer: a cycle model of the frame FSM plus a
// sample scoreboard, with glide values taken from hand-computed tables.
module tb_sine_sequencer;
    import sine_pkg::*;

    localparam int ACC_BITS = 16;
    localparam int FREQ_W   = ACC_BITS - 3;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STOP   = 2;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [1:0]        cfg_addr  = 2'd0;
    logic [15:0]       cfg_data  = 16'd0;
    logic [7:0]        sine_in   = 8'd0;
    logic              cfg_ready;
    logic [7:0]        subsample_phase;
    logic [FREQ_W-1:0] freq_increment;
    logic [7:0]        sample_out;
    logic              sample_valid;
    logic              running;

    int                testsRun     = 0;
    int                testsFailed  = 0;
    logic [7:0]        expSamples[$];
    int                mState       = M_IDLE;
    logic [7:0]        mPhase       = PH_IDLE;
    logic              mRun         = 1'b0;
    logic              lastAccepted = 1'b0;
    logic [FREQ_W-1:0] prevFreq     = '0;
    int                cycle        = 0;
    int                lastStrobe;
    int                strobes;
    int                glideExp[22] = '{100, 175, 231, 273, 304, 328, 346, 359, 369, 376, 382,
                                        386, 389, 391, 393, 394, 395, 396, 397, 398, 399, 400};

    always #5 clk = ~clk;

    sine_sequencer #(
        .ACC_BITS       (ACC_BITS),
        .GLIDE_SHIFT_RST(3'd4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .subsample_phase(subsample_phase),
        .freq_increment (freq_increment),
        .sine_in        (sine_in),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .running        (running)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        testsRun++;
        assert (obs === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] a, input logic [15:0] d);
        cfg_valid = v;
        cfg_addr  = a;
        cfg_data  = d;
    endtask

    // One clock: predict the edge from the model, then compare the DUT after it.
    task automatic tick();
        logic       expReady;
        logic       capture;
        logic       preIdle;
        logic [7:0] prePhase;
        int         nextState;
        logic [7:0] nextPhase;
        sine_in = 8'($urandom);
        #1;
        expReady = !rst && !(mState != M_IDLE && mPhase == PH_IDLE);
        checkOutput("cfg_ready", 32'(cfg_ready), 32'(expReady));
        capture      = !rst && mState != M_IDLE && mPhase == PH_IDLE;
        preIdle      = (mState == M_IDLE);
        prePhase     = mPhase;
        lastAccepted = cfg_valid && expReady;
        nextState    = mState;
        nextPhase    = mPhase + 8'd1;
        if (mState == M_IDLE) begin
            nextPhase = PH_IDLE;
            if (mRun) begin
                nextState = M_RUN;
                nextPhase = PH_LOAD;
            end
        end else if (mState == M_RUN) begin
            if (!mRun) nextState = M_STOP;
        end else if (mRun) begin
            nextState = M_RUN;
        end else if (mPhase == PH_IDLE) begin
            nextState = M_IDLE;
            nextPhase = PH_IDLE;
        end
        if (capture) expSamples.push_back(sine_in);
        @(posedge clk);
        cycle++;
        if (rst) begin
            mState = M_IDLE;
            mPhase = PH_IDLE;
            mRun   = 1'b0;
            expSamples.delete();
        end else begin
            mState = nextState;
            mPhase = nextPhase;
            if (lastAccepted && cfg_addr == CFG_CTRL) mRun = cfg_data[0];
        end
        #1;
        checkOutput("phase", 32'(subsample_phase), 32'(mPhase));
        checkOutput("running", 32'(running), 32'(mState != M_IDLE));
        checkOutput("sample_valid", 32'(sample_valid), 32'(capture));
        if (sample_valid) begin
            if (expSamples.size() > 0)
                checkOutput("sample_out", 32'(sample_out), 32'(expSamples.pop_front()));
            else
                checkOutput("sample_unexpected", 32'(sample_valid), 32'(0));
        end else if (rst || preIdle) begin
            checkOutput("sample_mute", 32'(sample_out), 32'(SAMPLE_MUTE));
        end
        if (!rst && !preIdle && prePhase != PH_IDLE)
            checkOutput("freq_stable", 32'(freq_increment), 32'(prevFreq));
        prevFreq = freq_increment;
    endtask

    task automatic waitPhase(input logic [7:0] p, input string tag);
        int n = 0;
        while (mPhase != p && n < 300) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(subsample_phase), 32'(p));
    endtask

    task automatic cfgWrite(input logic [1:0] a, input logic [15:0] d);
        int n = 0;
        applyStimulus(1'b1, a, d);
        do begin
            tick();
            n++;
        end while (!lastAccepted && n < 4);
        applyStimulus(1'b0, a, d);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset and idle
        applyStimulus(1'b0, 2'd0, 16'd0);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset_freq", 32'(freq_increment), 32'(0));
        checkOutput("reset_sample", 32'(sample_out), 32'(128));
        rst = 1'b0;
        repeat (20) tick();
        checkOutput("idle_ready", 32'(cfg_ready), 32'(1));

        // Glide off, start running
        cfgWrite(CFG_FREQ, 16'h0100);
        tick();
        checkOutput("freq_idle_load", 32'(freq_increment), 32'h100);
        cfgWrite(CFG_CTRL, 16'h0001);
        tick();
        checkOutput("first_load_phase", 32'(subsample_phase), 32'(255));
        tick();
        checkOutput("first_iter_phase", 32'(subsample_phase), 32'(0));
        lastStrobe = -1;
        strobes    = 0;
        repeat (600) begin
            tick();
            if (subsample_phase == PH_OUT)
                checkOutput("freq_at_out", 32'(freq_increment), 32'h100);
            if (sample_valid) begin
                checkOutput("strobe_slot", 32'(subsample_phase), 32'(10));
                if (lastStrobe >= 0)
                    checkOutput("strobe_period", 32'(cycle - lastStrobe), 32'(256));
                lastStrobe = cycle;
                strobes++;
            end
        end
        checkOutput("strobe_count", 32'(strobes), 32'(3));

        // Glide from 0 toward 400 with shift 2
        waitPhase(8'd20, "sync_20");
        cfgWrite(CFG_FREQ, 16'd0);
        waitPhase(8'd10, "sync_10");
        checkOutput("glide_start", 32'(freq_increment), 32'(0));
        cfgWrite(CFG_GLIDE, 16'd2);
        cfgWrite(CFG_FREQ, 16'd400);
        cfgWrite(CFG_CTRL, 16'd3);
        for (int k = 0; k < 22; k++) begin
            tick();
            waitPhase(8'd10, "glide_sync");
            checkOutput($sformatf("glide_%0d", k), 32'(freq_increment), 32'(glideExp[k]));
        end
        tick();
        waitPhase(8'd10, "glide_sync");
        checkOutput("glide_settled", 32'(freq_increment), 32'(400));

        // Config held across the update slot
        waitPhase(PH_IDLE, "slot_sync");
        applyStimulus(1'b1, CFG_FREQ, 16'd80);
        #1;
        checkOutput("ready_low_slot", 32'(cfg_ready), 32'(0));
        tick();
        checkOutput("target_held", 32'(freq_increment), 32'(400));
        checkOutput("ready_recovers", 32'(cfg_ready), 32'(1));
        tick();
        applyStimulus(1'b0, CFG_FREQ, 16'd0);
        waitPhase(8'd10, "down_sync");
        checkOutput("glide_down", 32'(freq_increment), 32'(320));

        // Stop then resume before the frame ends
        waitPhase(8'd100, "resume_sync");
        cfgWrite(CFG_CTRL, 16'd2);
        cfgWrite(CFG_CTRL, 16'd3);
        checkOutput("resume_running", 32'(running), 32'(1));
        checkOutput("resume_phase", 32'(subsample_phase), 32'(102));
        repeat (3) tick();

        // Stop at phase 3: frame completes, one last strobe, then mute
        waitPhase(8'd3, "stop_sync");
        cfgWrite(CFG_CTRL, 16'd2);
        strobes = 0;
        for (int n = 0; n < 20 && running; n++) begin
            tick();
            if (sample_valid) strobes++;
        end
        checkOutput("stop_strobes", 32'(strobes), 32'(1));
        checkOutput("stop_phase", 32'(subsample_phase), 32'(PH_IDLE));
        checkOutput("stop_running", 32'(running), 32'(0));
        tick();
        checkOutput("stop_mute", 32'(sample_out), 32'(128));
        repeat (5) tick();

        // Reset in the middle of a frame
        cfgWrite(CFG_CTRL, 16'd1);
        tick();
        waitPhase(8'd5, "rst_sync");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_phase", 32'(subsample_phase), 32'(PH_IDLE));
        checkOutput("rst_freq", 32'(freq_increment), 32'(0));
        checkOutput("rst_valid", 32'(sample_valid), 32'(0));
        repeat (20) tick();

        checkOutput("scoreboard_drained", 32'(expSamples.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
